// File: rtl/zoom_coproc_ctrl_if.sv
// Host, generator and frame-memory signals of the zoom coprocessor control unit.
// slave: the control unit. master: the host/generator/memory side driving it.
interface zoom_coproc_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 17
);
  // Host side
  logic [2:0]        instruction;
  logic              enable_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] data_out;
  logic              flag_done;
  logic              flag_error;
  logic              flag_zoom_max;
  logic              flag_zoom_min;
  logic [2:0]        zoom_lvl;
  // Address/algorithm generator
  logic              alg_start;
  logic [2:0]        alg_op;
  logic              alg_done;
  logic [DATA_W-1:0] alg_rdata;
  logic [1:0]        alg_wr_bank;
  // Work-bank to display-bank copy and VGA bank mux
  logic [ADDR_W-1:0] copy_rd_addr;
  logic [DATA_W-1:0] copy_rd_data;
  logic [ADDR_W-1:0] copy_wr_addr;
  logic [DATA_W-1:0] copy_wr_data;
  logic              copy_wr_en;
  logic [1:0]        vga_bank_sel;

  modport slave (
    input  instruction, enable_n, mem_addr, alg_done, alg_rdata, copy_rd_data,
    output data_out, flag_done, flag_error, flag_zoom_max, flag_zoom_min, zoom_lvl,
           alg_start, alg_op, alg_wr_bank, copy_rd_addr, copy_wr_addr, copy_wr_data,
           copy_wr_en, vga_bank_sel
  );

  modport master (
    output instruction, enable_n, mem_addr, alg_done, alg_rdata, copy_rd_data,
    input  data_out, flag_done, flag_error, flag_zoom_max, flag_zoom_min, zoom_lvl,
           alg_start, alg_op, alg_wr_bank, copy_rd_addr, copy_wr_addr, copy_wr_data,
           copy_wr_en, vga_bank_sel
  );
endinterface

// File: rtl/zoom_coproc_ctrl.sv
// Control unit of the image zoom coprocessor: decodes host instructions, tracks the zoom
// level, dispatches the generator and publishes the result to the display bank.
// Optional feature macro: ZOOM_PINGPONG_EN -- publish by swapping work/display banks
// instead of copying the frame pixel by pixel.
module zoom_coproc_ctrl #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned FRAME_W        = 320,
  parameter int unsigned FRAME_H        = 240,
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned RD_LATENCY     = 2,
  parameter int unsigned ZOOM_MAX_LVL   = 7,
  parameter int unsigned ZOOM_RESET_LVL = 4
) (
  input logic               clock,
  input logic               reset_n,
  zoom_coproc_ctrl_if.slave bus
);

  localparam int unsigned       NumPix   = FRAME_W * FRAME_H;
  localparam logic [2:0]        ZoomMax  = 3'(ZOOM_MAX_LVL);
  localparam logic [2:0]        ZoomRst  = 3'(ZOOM_RESET_LVL);
  localparam logic [2:0]        OpNop    = 3'd0;
  localparam logic [2:0]        OpLoad   = 3'd1;
  localparam logic [2:0]        OpStore  = 3'd2;
  localparam logic [2:0]        OpZinVp  = 3'd3;
  localparam logic [2:0]        OpZinRp  = 3'd4;
  localparam logic [2:0]        OpZoutMp = 3'd5;
  localparam logic [2:0]        OpZoutVd = 3'd6;
  localparam logic [2:0]        OpReset  = 3'd7;

  typedef enum logic [2:0] {StIdle, StMemop, StAlg, StCopy, StRst} state_e;

  state_e            state_q, state_d;
  logic              en_q;
  logic              issue, accept, reject;
  logic              is_zin, is_zout, zoom_ok;
  logic              alg_fin, copy_last;
  logic              start_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] data_out_q;
  logic              err_q;
  logic [2:0]        zoom_q, zoom_d;
  logic              zmax_q, zmin_q;
  logic [1:0]        vga_q, wr_bank_q;

  // Falling edge of enable_n, honoured only while idle.
  assign issue   = en_q & ~bus.enable_n & (state_q == StIdle);
  assign is_zin  = (bus.instruction == OpZinVp) || (bus.instruction == OpZinRp);
  assign is_zout = (bus.instruction == OpZoutMp) || (bus.instruction == OpZoutVd);
  assign zoom_ok = !((is_zin && zoom_q == ZoomMax) || (is_zout && zoom_q == 3'd0));
  assign accept  = issue && zoom_ok && (bus.instruction != OpNop);
  assign reject  = issue && !zoom_ok;
  assign alg_fin = (state_q == StAlg) && bus.alg_done;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (bus.instruction)
            OpLoad, OpStore: state_d = StMemop;
            OpReset:         state_d = StRst;
            default:         state_d = StAlg;
          endcase
        end
      end
      StMemop: if (bus.alg_done) state_d = StIdle;
`ifdef ZOOM_PINGPONG_EN
      StAlg:   if (bus.alg_done) state_d = StIdle;
`else
      StAlg:   if (bus.alg_done) state_d = StCopy;
`endif
      StCopy:  if (copy_last) state_d = StIdle;
      StRst:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Zoom level moves only when the generator finishes a zoom op, or on RESET.
  always_comb begin
    zoom_d = zoom_q;
    if (alg_fin) begin
      if ((op_q == OpZinVp) || (op_q == OpZinRp)) begin
        zoom_d = zoom_q + 3'd1;
      end else begin
        zoom_d = zoom_q - 3'd1;
      end
    end else if (state_q == StRst) begin
      zoom_d = ZoomRst;
    end
  end

  // Control registers: strobe sync, latched op, flags, zoom level and bank selects
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      en_q       <= 1'b1;
      start_q    <= 1'b0;
      op_q       <= OpNop;
      mem_addr_q <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
      zoom_q     <= ZoomRst;
      zmax_q     <= (ZoomRst == ZoomMax);
      zmin_q     <= (ZoomRst == 3'd0);
      vga_q      <= 2'd1;
      wr_bank_q  <= 2'd2;
    end else begin
      en_q    <= bus.enable_n;
      start_q <= accept && (bus.instruction != OpReset);
      if (accept) begin
        op_q       <= bus.instruction;
        mem_addr_q <= bus.mem_addr;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (reject) begin
        err_q <= 1'b1;
      end
      if ((state_q == StMemop) && bus.alg_done && (op_q == OpLoad)) begin
        data_out_q <= bus.alg_rdata;
      end
      zoom_q <= zoom_d;
      zmax_q <= (zoom_d == ZoomMax);
      zmin_q <= (zoom_d == 3'd0);
      if (state_q == StRst) begin
        err_q     <= 1'b0;
        vga_q     <= 2'd0;
        wr_bank_q <= 2'd2;
      end
`ifdef ZOOM_PINGPONG_EN
      if (alg_fin) begin
        vga_q     <= wr_bank_q;
        wr_bank_q <= (wr_bank_q == 2'd2) ? 2'd1 : 2'd2;
      end
`else
      if (copy_last) begin
        vga_q <= 2'd1;
      end
`endif
    end
  end

`ifdef ZOOM_PINGPONG_EN
  assign copy_last = 1'b0;
`else
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);

  logic                      rd_active_q;
  logic [ADDR_W-1:0]         rd_addr_q;
  logic [RD_LATENCY-1:0]     vld_sr_q;
  logic [ADDR_W-1:0]         addr_sr_q [RD_LATENCY];

  // Copy engine: one read per cycle, address/valid delayed to line up with read data
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_active_q <= 1'b0;
      rd_addr_q   <= '0;
      vld_sr_q    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        addr_sr_q[i] <= '0;
      end
    end else begin
      if (alg_fin) begin
        rd_active_q <= 1'b1;
        rd_addr_q   <= '0;
      end else if (rd_active_q) begin
        if (rd_addr_q == LastAddr) begin
          rd_active_q <= 1'b0;
          rd_addr_q   <= '0;
        end else begin
          rd_addr_q <= rd_addr_q + 1'b1;
        end
      end
      vld_sr_q[0]  <= rd_active_q;
      addr_sr_q[0] <= rd_addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr_q[i]  <= vld_sr_q[i-1];
        addr_sr_q[i] <= addr_sr_q[i-1];
      end
    end
  end

  assign copy_last = vld_sr_q[RD_LATENCY-1] && (addr_sr_q[RD_LATENCY-1] == LastAddr);
`endif

  // Outputs
  always_comb begin
    bus.data_out      = data_out_q;
    bus.flag_done     = (state_q == StIdle) || (state_q == StRst);
    bus.flag_error    = err_q;
    bus.flag_zoom_max = zmax_q;
    bus.flag_zoom_min = zmin_q;
    bus.zoom_lvl      = zoom_q;
    bus.alg_start     = start_q;
    bus.alg_op        = op_q;
    bus.alg_wr_bank   = wr_bank_q;
    bus.vga_bank_sel  = vga_q;
`ifdef ZOOM_PINGPONG_EN
    // The work-bank read port carries the host address during LOAD/STORE.
    bus.copy_rd_addr  = (state_q == StMemop) ? mem_addr_q : '0;
    bus.copy_wr_addr  = '0;
    bus.copy_wr_data  = '0;
    bus.copy_wr_en    = 1'b0;
`else
    // The work-bank read port carries the host address during LOAD/STORE.
    bus.copy_rd_addr  = (state_q == StMemop) ? mem_addr_q : rd_addr_q;
    bus.copy_wr_addr  = addr_sr_q[RD_LATENCY-1];
    bus.copy_wr_data  = bus.copy_rd_data;
    bus.copy_wr_en    = vld_sr_q[RD_LATENCY-1];
`endif
  end

endmodule

// File: tb/tb_zoom_coproc_ctrl.sv
// Self-checking bench for zoom_coproc_ctrl: a table of host operations with expected
// flags/levels, a scoreboard for display-bank writes, and hand-written busy/reset sequences.
module tb_zoom_coproc_ctrl;

  localparam int unsigned DW   = 8;
  localparam int unsigned FW   = 4;
  localparam int unsigned FH   = 2;
  localparam int unsigned AW   = 17;
  localparam int unsigned LAT  = 3;
  localparam int          NPIX = FW * FH;
`ifdef ZOOM_PINGPONG_EN
  localparam bit PingPong = 1'b1;
`else
  localparam bit PingPong = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  zoom_coproc_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  zoom_coproc_ctrl #(
    .DATA_W        (DW),
    .FRAME_W       (FW),
    .FRAME_H       (FH),
    .ADDR_W        (AW),
    .RD_LATENCY    (LAT),
    .ZOOM_MAX_LVL  (7),
    .ZOOM_RESET_LVL(4)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return DW'(a * 7 + 3) ^ 8'h5A;
  endfunction

  // Work-bank memory: data appears LAT cycles after the address.
  logic [AW-1:0] rd_pipe [LAT];
  always @(posedge clock) begin
    rd_pipe[0] <= bus.copy_rd_addr;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.copy_rd_data = pat(rd_pipe[LAT-1]);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [2:0] instr;
    int         delay;
    int         rdata;
    bit         exp_start;
    int         exp_zoom;
    int         exp_err;
    int         exp_max;
    int         exp_min;
    int         exp_dout;
    int         exp_vga;
  } vec_t;

  wr_t  sb_q[$];
  wr_t  exp_w;
  vec_t vecs[15];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_count, start_count, busy_count, cyc, first_wr_cyc, last_wr_cyc;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output monitor and write scoreboard
  always @(negedge clock) begin
    cyc++;
    if (reset_n) begin
      if (bus.alg_start) start_count++;
      if (!bus.flag_done) busy_count++;
      if (bus.copy_wr_en) begin
        if (wr_count == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_count++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wr_unexpected: got write addr %0h, expected no write",
                   bus.copy_wr_addr);
        end else begin
          exp_w = sb_q.pop_front();
          check("wr_addr", int'(bus.copy_wr_addr), int'(exp_w.addr));
          check("wr_data", int'(bus.copy_wr_data), int'(exp_w.data));
        end
      end
    end
  end

  function automatic vec_t mk(input logic [2:0] instr, input int delay, input int rdata,
                              input bit st, input int z, input int e, input int mx,
                              input int mn, input int dout, input int vga_def,
                              input int vga_pp);
    vec_t v;
    v.instr     = instr;
    v.delay     = delay;
    v.rdata     = rdata;
    v.exp_start = st;
    v.exp_zoom  = z;
    v.exp_err   = e;
    v.exp_max   = mx;
    v.exp_min   = mn;
    v.exp_dout  = dout;
    v.exp_vga   = PingPong ? vga_pp : vga_def;
    return v;
  endfunction

  task automatic wait_idle(input string name);
    int waited = 0;
    while (!bus.flag_done && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got flag_done=0 after 200 clk, expected 1", name);
    end
  endtask

  task automatic run_op(input int idx, input vec_t v);
    bit is_alg;
    int ew, eb;
    is_alg = v.exp_start && (v.instr >= 3'd3) && (v.instr <= 3'd6);
    ew     = (is_alg && !PingPong) ? NPIX : 0;
    eb     = v.exp_start ? (v.delay + 1 + ((ew > 0) ? NPIX + int'(LAT) : 0)) : 0;
    for (int i = 0; i < ew; i++) sb_q.push_back('{addr: AW'(i), data: pat(AW'(i))});
    wr_count    = 0;
    start_count = 0;
    busy_count  = 0;
    @(negedge clock);
    bus.instruction = v.instr;
    bus.alg_rdata   = DW'(v.rdata);
    bus.enable_n    = 1'b0;
    @(negedge clock);
    bus.enable_n = 1'b1;
    if (v.exp_start) begin
      check($sformatf("v%0d_alg_start", idx), int'(bus.alg_start), 1);
      check($sformatf("v%0d_alg_op", idx), int'(bus.alg_op), int'(v.instr));
      check($sformatf("v%0d_done_low", idx), int'(bus.flag_done), 0);
      if (v.delay > 0) repeat (v.delay) @(negedge clock);
      bus.alg_done = 1'b1;
      @(negedge clock);
      bus.alg_done = 1'b0;
    end
    wait_idle($sformatf("v%0d", idx));
    repeat (LAT + 2) @(negedge clock);
    check($sformatf("v%0d_zoom", idx), int'(bus.zoom_lvl), v.exp_zoom);
    check($sformatf("v%0d_err", idx), int'(bus.flag_error), v.exp_err);
    check($sformatf("v%0d_max", idx), int'(bus.flag_zoom_max), v.exp_max);
    check($sformatf("v%0d_min", idx), int'(bus.flag_zoom_min), v.exp_min);
    check($sformatf("v%0d_dout", idx), int'(bus.data_out), v.exp_dout);
    check($sformatf("v%0d_vga", idx), int'(bus.vga_bank_sel), v.exp_vga);
    check($sformatf("v%0d_wr_bank", idx), int'(bus.alg_wr_bank),
          (PingPong && v.exp_vga == 2) ? 1 : 2);
    check($sformatf("v%0d_starts", idx), start_count, int'(v.exp_start));
    check($sformatf("v%0d_writes", idx), wr_count, ew);
    check($sformatf("v%0d_busy_clk", idx), busy_count, eb);
    check($sformatf("v%0d_sb_left", idx), sb_q.size(), 0);
    if (ew > 0) check($sformatf("v%0d_wr_span", idx), last_wr_cyc - first_wr_cyc, ew - 1);
  endtask

  initial begin
    int wr_before;
    bus.instruction = 3'd0;
    bus.enable_n    = 1'b1;
    bus.mem_addr    = AW'(17'h00123);
    bus.alg_done    = 1'b0;
    bus.alg_rdata   = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_data_out", int'(bus.data_out), 0);
    check("rst_done", int'(bus.flag_done), 1);
    check("rst_err", int'(bus.flag_error), 0);
    check("rst_max", int'(bus.flag_zoom_max), 0);
    check("rst_min", int'(bus.flag_zoom_min), 0);
    check("rst_zoom", int'(bus.zoom_lvl), 4);
    check("rst_alg_start", int'(bus.alg_start), 0);
    check("rst_wr_en", int'(bus.copy_wr_en), 0);
    check("rst_rd_addr", int'(bus.copy_rd_addr), 0);
    check("rst_wr_addr", int'(bus.copy_wr_addr), 0);
    check("rst_vga", int'(bus.vga_bank_sel), 1);
    check("rst_wr_bank", int'(bus.alg_wr_bank), 2);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    //            instr dly rdata  st  z  e  mx mn dout  vga pp
    vecs[0]  = mk(3'd3, 5, 8'h00, 1, 5, 0, 0, 0, 8'h00, 1, 2);
    vecs[1]  = mk(3'd4, 0, 8'h00, 1, 6, 0, 0, 0, 8'h00, 1, 1);
    vecs[2]  = mk(3'd3, 2, 8'h00, 1, 7, 0, 1, 0, 8'h00, 1, 2);
    vecs[3]  = mk(3'd4, 0, 8'h00, 0, 7, 1, 1, 0, 8'h00, 1, 2);
    vecs[4]  = mk(3'd1, 1, 8'hA5, 1, 7, 0, 1, 0, 8'hA5, 1, 2);
    vecs[5]  = mk(3'd5, 3, 8'h00, 1, 6, 0, 0, 0, 8'hA5, 1, 1);
    vecs[6]  = mk(3'd2, 0, 8'h3C, 1, 6, 0, 0, 0, 8'hA5, 1, 1);
    vecs[7]  = mk(3'd7, 0, 8'h00, 0, 4, 0, 0, 0, 8'hA5, 0, 0);
    vecs[8]  = mk(3'd6, 1, 8'h00, 1, 3, 0, 0, 0, 8'hA5, 1, 2);
    vecs[9]  = mk(3'd5, 0, 8'h00, 1, 2, 0, 0, 0, 8'hA5, 1, 1);
    vecs[10] = mk(3'd6, 4, 8'h00, 1, 1, 0, 0, 0, 8'hA5, 1, 2);
    vecs[11] = mk(3'd5, 0, 8'h00, 1, 0, 0, 0, 1, 8'hA5, 1, 1);
    vecs[12] = mk(3'd6, 0, 8'h00, 0, 0, 1, 0, 1, 8'hA5, 1, 1);
    vecs[13] = mk(3'd0, 0, 8'h00, 0, 0, 1, 0, 1, 8'hA5, 1, 1);
    vecs[14] = mk(3'd3, 1, 8'h00, 1, 1, 0, 0, 0, 8'hA5, 1, 2);

    for (int i = 0; i < 15; i++) run_op(i, vecs[i]);

    // Strobes while busy are ignored: RESET during ALG, ZOUT during COPY
    for (int i = 0; i < (PingPong ? 0 : NPIX); i++)
      sb_q.push_back('{addr: AW'(i), data: pat(AW'(i))});
    wr_count    = 0;
    start_count = 0;
    @(negedge clock);
    bus.instruction = 3'd3;
    bus.enable_n    = 1'b0;
    @(negedge clock);
    bus.enable_n    = 1'b1;
    bus.instruction = 3'd7;
    @(negedge clock);
    bus.enable_n = 1'b0;
    @(negedge clock);
    bus.enable_n = 1'b1;
    bus.alg_done = 1'b1;
    @(negedge clock);
    bus.alg_done    = 1'b0;
    bus.instruction = 3'd5;
`ifndef ZOOM_PINGPONG_EN
    @(negedge clock);
    bus.enable_n = 1'b0;
    @(negedge clock);
    bus.enable_n = 1'b1;
`endif
    wait_idle("busy_strobe");
    repeat (LAT + 2) @(negedge clock);
    check("busy_zoom", int'(bus.zoom_lvl), 2);
    check("busy_err", int'(bus.flag_error), 0);
    check("busy_starts", start_count, 1);
    check("busy_vga", int'(bus.vga_bank_sel), 1);
    check("busy_writes", wr_count, PingPong ? 0 : NPIX);

    // reset_n low in the middle of the publish step
    for (int i = 0; i < (PingPong ? 0 : NPIX); i++)
      sb_q.push_back('{addr: AW'(i), data: pat(AW'(i))});
    wr_count = 0;
    @(negedge clock);
    bus.instruction = 3'd4;
    bus.enable_n    = 1'b0;
    @(negedge clock);
    bus.enable_n = 1'b1;
    bus.alg_done = 1'b1;
    @(negedge clock);
    bus.alg_done = 1'b0;
    repeat (5) @(negedge clock);
`ifndef ZOOM_PINGPONG_EN
    check("mid_copy_started", int'(wr_count > 0 && wr_count < NPIX), 1);
`endif
    wr_before = wr_count;
    reset_n   = 1'b0;
    @(negedge clock);
    check("abort_wr_en", int'(bus.copy_wr_en), 0);
    check("abort_zoom", int'(bus.zoom_lvl), 4);
    check("abort_done", int'(bus.flag_done), 1);
    check("abort_vga", int'(bus.vga_bank_sel), 1);
    sb_q.delete();
    reset_n = 1'b1;
    repeat (LAT + 4) @(negedge clock);
    check("abort_no_more_wr", wr_count, wr_before);
    check("abort_idle_done", int'(bus.flag_done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
